// File: rtl/conv_fprop_mac_pipe.sv
// Pipelined signed MAC for conv_fprop: input regs, product regs, accumulate/select
// regs, then a round/shift/saturate output register. A single ce freezes every stage.
module conv_fprop_mac_pipe #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int ACC_WIDTH  = 24,
    parameter int dout_WIDTH = 10,
    parameter int SHIFT      = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    input  logic                         mode,
    input  logic                         first,
    input  logic                         last,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         dout_ovf
);

    // Handshake: a beat moves on every edge where valid && ready; ready here is
    // the global advance enable, low only while a held result is not taken.
    localparam int SW     = ACC_WIDTH + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [SW-1:0] RND = (SHIFT > 0) ? (SW'(1) <<< RND_SH) : '0;
    localparam logic signed [SW-1:0] DMAX = {{(SW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] DMIN = {{(SW-dout_WIDTH+1){1'b1}}, {(dout_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic ce;

    logic                         s1_valid_q, s1_mode_q, s1_first_q, s1_last_q;
    logic signed [din0_WIDTH-1:0] s1_a_q;
    logic signed [din1_WIDTH-1:0] s1_b_q;

    logic                        s2_valid_q, s2_mode_q, s2_first_q, s2_last_q;
    logic signed [ACC_WIDTH-1:0] s2_prod_q, prod_d;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        sticky_q, sticky_d;
    logic signed [SW-1:0]        sum;
    logic                        add_clamp;

    logic                        s3_emit_q, s3_emit_d;
    logic signed [ACC_WIDTH-1:0] s3_val_q, s3_val_d;
    logic                        s3_stk_q, s3_stk_d;

    logic signed [SW-1:0]         rnd;
    logic signed [dout_WIDTH-1:0] dout_d;
    logic                         ovf_d;
    logic                         dout_valid_q, dout_ovf_q;
    logic signed [dout_WIDTH-1:0] dout_q;

    assign ce         = !dout_valid_q || dout_ready;
    assign din_ready  = ce;
    assign dout_valid = dout_valid_q;
    assign dout       = dout_q;
    assign dout_ovf   = dout_ovf_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (ce) begin
            s1_valid_q <= din_valid;
            s1_mode_q  <= mode;
            s1_first_q <= first;
            s1_last_q  <= last;
            s1_a_q     <= din0;
            s1_b_q     <= din1;
        end
    end

    // Operands are sign-extended to the accumulator width so the product lands
    // already extended; ACC_WIDTH >= din0_WIDTH+din1_WIDTH keeps it exact.
    always_comb begin
        prod_d = ACC_WIDTH'(s1_a_q) * ACC_WIDTH'(s1_b_q);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
        end else if (ce) begin
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_prod_q  <= prod_d;
        end
    end

    always_comb begin
        sum       = SW'(acc_q) + SW'(s2_prod_q);
        add_clamp = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        if (s2_first_q) begin
            acc_d    = s2_prod_q;
            sticky_d = 1'b0;
        end else begin
            acc_d    = add_clamp ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0];
            sticky_d = sticky_q | add_clamp;
        end
        s3_emit_d = s2_valid_q && (!s2_mode_q || s2_last_q);
        s3_val_d  = s2_mode_q ? acc_d : s2_prod_q;
        s3_stk_d  = s2_mode_q && sticky_d;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            s3_emit_q <= 1'b0;
            s3_val_q  <= '0;
            s3_stk_q  <= 1'b0;
        end else if (ce) begin
            if (s2_valid_q && s2_mode_q) begin
                acc_q    <= acc_d;
                sticky_q <= sticky_d;
            end
            s3_emit_q <= s3_emit_d;
            s3_val_q  <= s3_val_d;
            s3_stk_q  <= s3_stk_d;
        end
    end

    // One extra headroom bit lets the rounding constant be added without wrap.
    always_comb begin
        rnd    = (SW'(s3_val_q) + RND) >>> SHIFT;
        dout_d = rnd[dout_WIDTH-1:0];
        ovf_d  = s3_stk_q;
        if (rnd > DMAX) begin
            dout_d = DMAX[dout_WIDTH-1:0];
            ovf_d  = 1'b1;
        end else if (rnd < DMIN) begin
            dout_d = DMIN[dout_WIDTH-1:0];
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            dout_ovf_q   <= 1'b0;
        end else if (ce) begin
            dout_valid_q <= s3_emit_q;
            if (s3_emit_q) begin
                dout_q     <= dout_d;
                dout_ovf_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_conv_fprop_mac_pipe.sv
// Bench for conv_fprop_mac_pipe: two instances (ACC 24/SHIFT 0 and ACC 20/SHIFT 2)
// share one stimulus stream and are scored against an arithmetic reference model.
module tb_conv_fprop_mac_pipe;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b1;
    logic       din_valid = 1'b0;
    logic       mode = 1'b0, first = 1'b0, last = 1'b0;
    logic       dout_ready = 1'b1;
    logic [9:0] din0 = '0, din1 = '0;

    logic       din_ready0, din_ready1, dout_valid0, dout_valid1, dout_ovf0, dout_ovf1;
    logic [9:0] dout0, dout1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [10:0] exp0_q[$], exp1_q[$], dir0_q[$], dir1_q[$];
    int          lat0_q[$], lat1_q[$];
    bit          lat_chk = 1'b0;
    longint      acc0 = 0, acc1 = 0;
    bit          stk0 = 1'b0, stk1 = 1'b0;
    bit          stall0 = 1'b0, stall1 = 1'b0;
    logic [10:0] prev0, prev1;
    bit          pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit          rnd_done;

    conv_fprop_mac_pipe #(.ID(0)) u_dut0 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_valid(din_valid), .din_ready(din_ready0),
        .din0(din0), .din1(din1), .mode(mode), .first(first), .last(last),
        .dout_valid(dout_valid0), .dout_ready(dout_ready), .dout(dout0), .dout_ovf(dout_ovf0)
    );

    conv_fprop_mac_pipe #(.ID(1), .ACC_WIDTH(20), .SHIFT(2)) u_dut1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din_valid(din_valid), .din_ready(din_ready1),
        .din0(din0), .din1(din1), .mode(mode), .first(first), .last(last),
        .dout_valid(dout_valid1), .dout_ready(dout_ready), .dout(dout1), .dout_ovf(dout_ovf1)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] dv(input int v, input bit o);
        logic [9:0] t;
        t = 10'(v);
        return {o, t};
    endfunction

    // Reference narrowing: floor-shift after adding half an LSB, then clamp to 10 bits.
    function automatic logic [10:0] narrow_m(input longint x, input int sh, input bit stk);
        longint r;
        bit     c;
        r = x;
        c = 1'b0;
        if (sh > 0) r = (x + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 511) begin
            r = 511;
            c = 1'b1;
        end else if (r < -512) begin
            r = -512;
            c = 1'b1;
        end
        return {stk | c, r[9:0]};
    endfunction

    task automatic model_beat(input longint p, input bit md, input bit f, input bit l,
                              input int aw, input int sh, inout longint acc, inout bit stk,
                              output bit emit, output logic [10:0] res);
        longint s, lim;
        emit = 1'b0;
        res  = '0;
        if (!md) begin
            emit = 1'b1;
            res  = narrow_m(p, sh, 1'b0);
        end else begin
            if (f) begin
                acc = p;
                stk = 1'b0;
            end else begin
                s   = acc + p;
                lim = longint'(1) <<< (aw - 1);
                if (s > lim - 1) begin
                    acc = lim - 1;
                    stk = 1'b1;
                end else if (s < -lim) begin
                    acc = -lim;
                    stk = 1'b1;
                end else begin
                    acc = s;
                end
            end
            if (l) begin
                emit = 1'b1;
                res  = narrow_m(acc, sh, stk);
            end
        end
    endtask

    // Monitor: handshake rule, stall hold, scoreboard and latency, all at negedge.
    always @(negedge ap_clk) begin
        logic [10:0] r0, r1;
        bit          e0, e1;
        longint      p;
        int          lt;
        if (ap_rst_n) begin
            chk("din_ready0", din_ready0, !(dout_valid0 && !dout_ready));
            chk("din_ready1", din_ready1, !(dout_valid1 && !dout_ready));
            if (stall0) chk("hold0", {dout_ovf0, dout0}, prev0);
            if (stall1) chk("hold1", {dout_ovf1, dout1}, prev1);
            stall0 = dout_valid0 && !dout_ready;
            stall1 = dout_valid1 && !dout_ready;
            prev0  = {dout_ovf0, dout0};
            prev1  = {dout_ovf1, dout1};
            if (dout_valid0 && dout_ready) begin
                chk("sb0_has", exp0_q.size() > 0, 1);
                if (exp0_q.size() > 0) chk("sb0", {dout_ovf0, dout0}, exp0_q.pop_front());
                if (dir0_q.size() > 0) chk("dir0", {dout_ovf0, dout0}, dir0_q.pop_front());
                if (lat0_q.size() > 0) begin
                    lt = lat0_q.pop_front();
                    if (lat_chk) chk("lat0", cyc, lt + 3);
                end
            end
            if (dout_valid1 && dout_ready) begin
                chk("sb1_has", exp1_q.size() > 0, 1);
                if (exp1_q.size() > 0) chk("sb1", {dout_ovf1, dout1}, exp1_q.pop_front());
                if (dir1_q.size() > 0) chk("dir1", {dout_ovf1, dout1}, dir1_q.pop_front());
                if (lat1_q.size() > 0) begin
                    lt = lat1_q.pop_front();
                    if (lat_chk) chk("lat1", cyc, lt + 3);
                end
            end
            if (din_valid && din_ready0) begin
                p = longint'($signed(din0)) * longint'($signed(din1));
                model_beat(p, mode, first, last, 24, 0, acc0, stk0, e0, r0);
                model_beat(p, mode, first, last, 20, 2, acc1, stk1, e1, r1);
                if (e0) begin
                    exp0_q.push_back(r0);
                    lat0_q.push_back(cyc + 1);
                end
                if (e1) begin
                    exp1_q.push_back(r1);
                    lat1_q.push_back(cyc + 1);
                end
            end
        end
    end

    task automatic send(input int a, input int b, input bit md, input bit f, input bit l);
        bit ok;
        int n;
        n = 0;
        din0 = 10'(a);
        din1 = 10'(b);
        mode = md;
        first = f;
        last = l;
        din_valid = 1'b1;
        do begin
            @(negedge ap_clk);
            ok = din_ready0;
            @(posedge ap_clk);
            #1;
            n++;
        end while (!ok && n < 200);
        chk("send_accept", ok, 1);
        din_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0 || dout_valid0) && n < 200) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk("drain0", exp0_q.size(), 0);
        chk("drain1", exp1_q.size(), 0);
        chk("dir_left", dir0_q.size() + dir1_q.size(), 0);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        exp0_q.delete(); exp1_q.delete(); dir0_q.delete(); dir1_q.delete();
        lat0_q.delete(); lat1_q.delete();
        acc0 = 0; acc1 = 0; stk0 = 1'b0; stk1 = 1'b0; stall0 = 1'b0; stall1 = 1'b0;
        #1;
        chk("rst_async_valid0", dout_valid0, 0);
        chk("rst_async_valid1", dout_valid1, 0);
        chk("rst_async_dout0", {dout_ovf0, dout0}, 0);
        chk("rst_async_dout1", {dout_ovf1, dout1}, 0);
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_dout0", {dout_valid0, dout_ovf0, dout0}, 0);
        chk("rst_dout1", {dout_valid1, dout_ovf1, dout1}, 0);
        chk("rst_ready0", din_ready0, 1);
        chk("rst_ready1", din_ready1, 1);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        repeat (5) begin
            @(negedge ap_clk);
            chk("idle_valid0", dout_valid0, 0);
            chk("idle_valid1", dout_valid1, 0);
            chk("idle_ready0", din_ready0, 1);
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        @(posedge ap_clk);
        #1;
        do_reset();
        lat_chk = 1'b1;

        // mode 0 latency and back-to-back stream
        dir0_q.push_back(dv(-21, 0)); dir1_q.push_back(dv(-5, 0));
        send(3, -7, 0, 0, 0);
        wait_drain();
        dir0_q.push_back(dv(1, 0)); dir0_q.push_back(dv(4, 0)); dir0_q.push_back(dv(16, 0));
        dir1_q.push_back(dv(0, 0)); dir1_q.push_back(dv(1, 0)); dir1_q.push_back(dv(4, 0));
        send(1, 1, 0, 0, 0); send(2, 2, 0, 0, 0); send(4, 4, 0, 0, 0);
        wait_drain();

        // accumulate group, then single-beat group
        dir0_q.push_back(dv(100, 0)); dir1_q.push_back(dv(25, 0));
        send(1, 2, 1, 1, 0); send(3, 4, 1, 0, 0); send(5, 6, 1, 0, 0); send(7, 8, 1, 0, 1);
        dir0_q.push_back(dv(-25, 0)); dir1_q.push_back(dv(-6, 0));
        send(-5, 5, 1, 1, 1);
        wait_drain();

        // saturation of output and of the accumulator
        dir0_q.push_back(dv(511, 1)); dir1_q.push_back(dv(511, 1));
        send(-512, -512, 0, 0, 0);
        dir0_q.push_back(dv(-512, 1)); dir1_q.push_back(dv(-512, 1));
        send(-512, 511, 0, 0, 0);
        dir0_q.push_back(dv(511, 1)); dir1_q.push_back(dv(511, 1));
        send(-512, -512, 1, 1, 0); send(-512, -512, 1, 0, 0);
        send(-512, -512, 1, 0, 0); send(-512, -512, 1, 0, 1);
        wait_drain();

        // rounding half toward +inf
        dir0_q.push_back(dv(10, 0)); dir0_q.push_back(dv(-10, 0)); dir0_q.push_back(dv(6, 0));
        dir1_q.push_back(dv(3, 0)); dir1_q.push_back(dv(-2, 0)); dir1_q.push_back(dv(2, 0));
        send(2, 5, 0, 0, 0); send(-2, 5, 0, 0, 0); send(2, 3, 0, 0, 0);
        wait_drain();

        // backpressure with ready pattern 1,0,0,1,0,1
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 0, 0, 0);
            end
            begin
                for (int k = 0; k < 24; k++) begin
                    dout_ready = pat[k % 6];
                    @(posedge ap_clk);
                    #1;
                end
                dout_ready = 1'b1;
            end
        join
        wait_drain();

        // reset with beats in flight, then accumulate without first from a cleared acc
        for (int i = 0; i < 4; i++)
            send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        do_reset();
        lat_chk = 1'b1;
        dir0_q.push_back(dv(13, 0)); dir1_q.push_back(dv(3, 0));
        send(3, 4, 1, 0, 0); send(1, 1, 1, 0, 1);
        wait_drain();

        // random mix of modes, group flags, gaps and ready
        lat_chk = 1'b0;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    send(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                         1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge ap_clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                do begin
                    dout_ready = $urandom_range(0, 3) != 0;
                    @(posedge ap_clk);
                    #1;
                end while (!rnd_done);
                dout_ready = 1'b1;
            end
        join
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
